// File: rtl/debayer_line_sched_pkg.sv
// Shared types and ring constants for the de-Bayer line scheduler and datapath.
package debayer_line_sched_pkg;

  localparam int unsigned NUM_LINE_SLOTS = 4;
  localparam int unsigned RING_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_ISSUE,
    ST_READ,
    ST_WAIT,
    ST_FLUSH
  } debayer_sched_state_t;

endpackage

// File: rtl/debayer_rd_watchdog.sv
// Read-pass watchdog: counts cycles from start, raises expire after RD_TIMEOUT cycles.
module debayer_rd_watchdog #(
  parameter int unsigned RD_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW = $clog2(RD_TIMEOUT + 1);

  logic [CW-1:0] count;
  logic          run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      run   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      run   <= 1'b0;
    end else if (start) begin
      count <= '0;
      run   <= 1'b1;
    end else if (run && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = run && (count == CW'(RD_TIMEOUT - 1));

endmodule

// File: rtl/debayer_line_sched.sv
// Frame sequencer for the 4-line de-Bayer ring buffer.
// Define DEBAYER_FLUSH_EN to re-read the edge lines with extra passes after EOF.
module debayer_line_sched
  import debayer_line_sched_pkg::*;
#(
  parameter int unsigned LINES_PER_FRAME = 480,
  parameter int unsigned PRIME_LINES     = 3,
  parameter int unsigned RD_TIMEOUT      = 4096,
  localparam int unsigned LW             = $clog2(LINES_PER_FRAME + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              line_end,
  input  logic              rd_done,
  input  logic              err_clr,
  output logic [RING_W-1:0] wr_line_sel,
  output logic [RING_W-1:0] rd_phase,
  output logic              rgb_valid,
  output logic              rd_start,
  output logic [LW-1:0]     lines_in,
  output logic [LW-1:0]     lines_out,
  output logic              busy,
  output logic              overflow,
  output logic              timeout
);

  debayer_sched_state_t state;
  logic                 eof_seen;
  logic                 le_ok, rd_ok, issue_ok, eof_now, ovf_set, to_set;
  logic [LW-1:0]        lines_in_nx, lines_out_nx, backlog;
  logic                 wd_start, wd_clear, wd_expire;
`ifdef DEBAYER_FLUSH_EN
  localparam int unsigned FW = $clog2(PRIME_LINES + 1);
  logic [FW-1:0]        flush_cnt;
`endif

  // A line_end coincident with frame_start belongs to the aborted frame and is dropped.
  assign le_ok        = line_end && !frame_start && (state != ST_IDLE) &&
                        (lines_in != LW'(LINES_PER_FRAME));
  assign rd_ok        = rd_done && !frame_start && (state == ST_READ);
  assign lines_in_nx  = lines_in + LW'(le_ok);
  assign lines_out_nx = lines_out + LW'(rd_ok);
  assign issue_ok     = {1'b0, lines_in_nx} >= ({1'b0, lines_out_nx} + (LW+1)'(PRIME_LINES));
  assign eof_now      = eof_seen || frame_end;
  assign backlog      = lines_in - lines_out;
  assign ovf_set      = le_ok && ({1'b0, backlog} >= (LW+1)'(NUM_LINE_SLOTS));
  assign to_set       = (state == ST_READ) && !frame_start && !rd_done && wd_expire;
  assign busy         = (state != ST_IDLE);

  assign wd_start = (state == ST_ISSUE) && !frame_start;
  assign wd_clear = (state == ST_READ) ? (frame_start || rd_done || wd_expire) : !wd_start;

  debayer_rd_watchdog #(.RD_TIMEOUT(RD_TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .start  (wd_start),
    .clear  (wd_clear),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_line_sel <= '0;
      rd_phase    <= '1;
      rgb_valid   <= 1'b0;
      rd_start    <= 1'b0;
      lines_in    <= '0;
      lines_out   <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
      eof_seen    <= 1'b0;
`ifdef DEBAYER_FLUSH_EN
      flush_cnt   <= '0;
`endif
    end else begin
      rd_start <= 1'b0;
      overflow <= ovf_set | (overflow & ~err_clr);
      timeout  <= to_set  | (timeout  & ~err_clr);
      if (frame_start) begin
        state       <= ST_PRIME;
        rgb_valid   <= 1'b0;
        wr_line_sel <= '0;
        rd_phase    <= '1;
        lines_in    <= '0;
        lines_out   <= '0;
        eof_seen    <= 1'b0;
`ifdef DEBAYER_FLUSH_EN
        flush_cnt   <= '0;
`endif
      end else if (state != ST_IDLE) begin
        if (le_ok) begin
          wr_line_sel <= wr_line_sel + 1'b1;
          lines_in    <= lines_in_nx;
        end
        if (frame_end) eof_seen <= 1'b1;
        case (state)
          ST_PRIME: begin
            if (issue_ok) begin
              rgb_valid <= 1'b1;
              state     <= ST_ISSUE;
            end else if (frame_end) begin
              rgb_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          ST_ISSUE: begin
            rd_start <= 1'b1;
            state    <= ST_READ;
          end
          ST_READ, ST_WAIT: begin
            if (rd_ok) begin
              lines_out <= lines_out_nx;
              rd_phase  <= rd_phase + 1'b1;
            end
            if (state == ST_READ && !rd_ok) begin
              if (wd_expire) begin
                rgb_valid <= 1'b0;
                state     <= ST_IDLE;
              end
            end else if (issue_ok) begin
              state <= ST_ISSUE;
            end else if (eof_now) begin
`ifdef DEBAYER_FLUSH_EN
              state     <= ST_FLUSH;
`else
              rgb_valid <= 1'b0;
              state     <= ST_IDLE;
`endif
            end else begin
              state <= ST_WAIT;
            end
          end
`ifdef DEBAYER_FLUSH_EN
          ST_FLUSH: begin
            if (flush_cnt == FW'(PRIME_LINES - 1)) begin
              rgb_valid <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
              state     <= ST_ISSUE;
            end
          end
`endif
          default: begin
            rgb_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debayer_line_sched.sv
// Self-checking bench for debayer_line_sched (honours DEBAYER_FLUSH_EN).
module tb_debayer_line_sched;

  localparam int unsigned LPF = 8;
  localparam int unsigned TO  = 64;
  localparam int unsigned LW  = $clog2(LPF + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0, frame_end = 1'b0, line_end = 1'b0;
  logic          rd_done = 1'b0, err_clr = 1'b0;
  logic [1:0]    wr_line_sel, rd_phase;
  logic          rgb_valid, rd_start, busy, overflow, timeout;
  logic [LW-1:0] lines_in, lines_out;

  int checks = 0;
  int failures = 0;
  int n_starts = 0;
  int m_in, m_out, m_phase;
  bit m_ovf;

  debayer_line_sched #(
    .LINES_PER_FRAME (LPF),
    .PRIME_LINES     (3),
    .RD_TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_end    (line_end),
    .rd_done     (rd_done),
    .err_clr     (err_clr),
    .wr_line_sel (wr_line_sel),
    .rd_phase    (rd_phase),
    .rgb_valid   (rgb_valid),
    .rd_start    (rd_start),
    .lines_in    (lines_in),
    .lines_out   (lines_out),
    .busy        (busy),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_start === 1'b1) n_starts <= n_starts + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // bit0 frame_start, bit1 frame_end, bit2 line_end, bit3 rd_done, bit4 err_clr
  task automatic pulse(input int m);
    @(negedge clk);
    frame_start = m[0];
    frame_end   = m[1];
    line_end    = m[2];
    rd_done     = m[3];
    err_clr     = m[4];
    @(negedge clk);
    {frame_start, frame_end, line_end, rd_done, err_clr} = '0;
  endtask

  task automatic model_line();
    if (m_in < LPF) begin
      if (m_in - m_out >= 4) m_ovf = 1'b1;
      m_in++;
    end
  endtask

  task automatic wait_start(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (rd_start === 1'b1) seen = 1'b1;
    end
    chk(tag, seen, 1);
  endtask

  task automatic do_pass();
    chk("pass_phase", rd_phase, m_phase);
    repeat ($urandom_range(1, 40)) @(negedge clk);
    pulse(8);
    m_out++;
    m_phase = (m_phase + 1) % 4;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    chk(tag, busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb_valid"}, rgb_valid, 0);
    chk({tag, "_rd_start"}, rd_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_phase"}, rd_phase, 3);
    chk({tag, "_wr_sel"}, wr_line_sel, 0);
    chk({tag, "_lines_in"}, lines_in, 0);
    chk({tag, "_lines_out"}, lines_out, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic run_frame(input int n);
    int s0;
    int exp_out;
    s0 = n_starts;
    pulse(1);
    m_in = 0; m_out = 0; m_phase = 3; m_ovf = 1'b0;
    chk("sof_busy", busy, 1);
    chk("sof_phase", rd_phase, 3);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      pulse(4);
      model_line();
      chk("frm_rgb_valid", rgb_valid, (m_in >= 3) ? 1 : 0);
      chk("frm_wr_sel", wr_line_sel, m_in % 4);
      chk("frm_lines_in", lines_in, m_in);
      while (m_in >= m_out + 3) begin
        wait_start("frm_rd_start", 4);
        do_pass();
        chk("frm_lines_out", lines_out, m_out);
      end
    end
    pulse(2);
`ifdef DEBAYER_FLUSH_EN
    for (int k = 0; k < 2; k++) begin
      wait_start("flush_rd_start", 6);
      do_pass();
    end
    exp_out = m_in;
`else
    exp_out = m_in - 2;
`endif
    wait_idle("eof_idle");
    chk("eof_rgb_valid", rgb_valid, 0);
    chk("eof_lines_in", lines_in, m_in);
    chk("eof_lines_out", lines_out, exp_out);
    chk("eof_passes", n_starts - s0, exp_out);
    chk("eof_overflow", overflow, m_ovf);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    for (int f = 0; f < 6; f++) run_frame($urandom_range(3, LPF));

    // Frame ending while still priming
    begin
      int s0;
      s0 = n_starts;
      pulse(1); pulse(4); pulse(4); pulse(2);
      chk("short_busy", busy, 0);
      chk("short_lines_in", lines_in, 2);
      chk("short_rgb_valid", rgb_valid, 0);
      repeat (3) @(negedge clk);
      chk("short_passes", n_starts - s0, 0);
    end

    // Read pass that never completes
    pulse(1); pulse(4); pulse(4); pulse(4);
    wait_start("to_rd_start", 4);
    for (int i = 1; i < TO; i++) @(negedge clk);
    chk("to_early", timeout, 0);
    chk("to_busy_before", busy, 1);
    @(negedge clk);
    chk("to_set", timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_rgb_valid", rgb_valid, 0);
    pulse(16);
    chk("to_cleared", timeout, 0);

    // Writer laps reader, then saturates at LPF
    pulse(1);
    m_in = 0; m_out = 0; m_ovf = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      pulse(4);
      model_line();
      chk("ovf_flag", overflow, m_ovf);
      chk("ovf_wr_sel", wr_line_sel, m_in % 4);
      chk("ovf_lines_in", lines_in, m_in);
    end

    // Mid-frame abort
    pulse(1);
    chk("abort_rgb_valid", rgb_valid, 0);
    chk("abort_lines_in", lines_in, 0);
    chk("abort_lines_out", lines_out, 0);
    chk("abort_phase", rd_phase, 3);
    chk("abort_busy", busy, 1);
    chk("abort_overflow_kept", overflow, 1);
    for (int i = 1; i <= 3; i++) begin
      pulse(4);
      chk("reprime_rgb_valid", rgb_valid, (i == 3) ? 1 : 0);
    end
    wait_start("reprime_rd_start", 4);

    // line_end together with rd_done: decision uses updated counts
    pulse(4 | 8);
    chk("coinc_lines_in", lines_in, 4);
    chk("coinc_lines_out", lines_out, 1);
    chk("coinc_phase", rd_phase, 0);
    wait_start("coinc_rd_start", 2);

    // Asynchronous reset mid-READ
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debayer_line_sched.md
# debayer_line_sched

Frame-level sequencer for the 4-line de-Bayer line buffer on the byte clock. It tracks SOF/EOF and per-line write completions from the CSI-2 receive path, and selects the write slot. It launches one read pass per output line once three lines are buffered and drives the read-side enable and ring phase into the de-Bayer datapath. It also flags writer-laps-reader overflow and stuck read passes.

## Interface
- LINES_PER_FRAME, 480, active lines per frame; counter ceiling
- PRIME_LINES, 3, lines buffered before the first read pass (fixed by 3-line kernel)
- RD_TIMEOUT, 4096, max cycles between rd_start and rd_done
- clk  in  1  byte clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  1-cycle pulse, SOF short packet
- frame_end  in  1  1-cycle pulse, EOF short packet
- line_end  in  1  1-cycle pulse, writer finished storing one line
- rd_done  in  1  1-cycle pulse, datapath finished one read pass
- err_clr  in  1  clears sticky errors
- wr_line_sel  out  2  ring slot the writer fills next
- rd_phase  out  2  ring phase of current read pass; 3 on first pass
- rgb_valid  out  1  read-side enable; low holds datapath read logic in reset
- rd_start  out  1  1-cycle pulse launching one read pass
- lines_in  out  LW  lines written this frame, LW = $clog2(LINES_PER_FRAME+1)
- lines_out  out  LW  read passes completed this frame
- busy  out  1  high in any state except IDLE
- overflow  out  1  sticky: writer entered a slot still in use
- timeout  out  1  sticky: read pass exceeded RD_TIMEOUT

## Operation
- Reset values: all outputs 0, except rd_phase=3. State is IDLE.
- States: IDLE, PRIME, ISSUE, READ, WAIT, FLUSH.
- IDLE: on frame_start, clear lines_in, lines_out and wr_line_sel, set rd_phase=3, then go to PRIME.
- line_end, in any non-IDLE state: wr_line_sel += 1 (wraps 3->0). lines_in += 1, saturating at LINES_PER_FRAME; further line_end pulses are ignored.
- Overflow check on line_end: if lines_in - lines_out >= 4 before the increment, set overflow. The line is still counted.
- PRIME: when lines_in reaches PRIME_LINES, set rgb_valid=1 and go to ISSUE.
- ISSUE: pulse rd_start for exactly one cycle, then go to READ.
- READ: on rd_done, lines_out += 1 and rd_phase += 1 (wraps). Next state:
  - ISSUE if lines_in >= lines_out+1+PRIME_LINES;
  - else FLUSH or IDLE if EOF has been seen;
  - else WAIT.
- WAIT: a line_end that satisfies the ISSUE condition -> ISSUE. If EOF has been seen -> FLUSH or IDLE.
- EOF is a latched flag, set by frame_end in any non-IDLE state.
- frame_end in PRIME (lines_in < PRIME_LINES): go to IDLE with no read passes.
- Leaving to IDLE always drops rgb_valid in the same edge.
- frame_start in any non-IDLE state aborts the frame: rgb_valid=0 for one cycle, counters cleared, then PRIME. Sticky errors are kept.
- Timeout: a cycle counter runs in READ. Reaching RD_TIMEOUT sets timeout and goes to IDLE.
- line_end and rd_done in the same cycle: both take effect, and the ISSUE decision uses the updated counts.
- err_clr clears overflow and timeout. If an error sets in the same cycle, set wins.

## Timing
- rd_start is asserted the cycle after the enabling condition is registered (frame_start->PRIME, line_end->ISSUE, rd_done->ISSUE): one cycle of latency.
- rgb_valid rises on the same edge that enters the first ISSUE. The first rd_start is therefore one cycle after rgb_valid rises.
- rd_phase and lines_out update on the edge after rd_done. Both are stable before the next rd_start.
- Minimum spacing between consecutive rd_start pulses is 2 cycles (rd_done -> ISSUE -> pulse).

## Configuration
- DEBAYER_FLUSH_EN defined: after EOF and exhaustion of normal passes, FLUSH issues PRIME_LINES-1 (=2) extra passes, each as ISSUE/READ. rd_phase advances normally; the writer is idle, so the edge lines are re-read. Then go to IDLE. lines_out ends equal to lines_in.
- DEBAYER_FLUSH_EN undefined: FLUSH is unreachable and the frame ends with lines_out = lines_in - 2.

## Structure
- The shared package holds the state enum debayer_sched_state_t and the ring constants NUM_LINE_SLOTS=4 and RING_W=2, shared with the de-Bayer datapath.
- One sub-module, debayer_rd_watchdog: a cycle counter with start/clear/expire for RD_TIMEOUT. All other logic stays in one FSM plus counters.

## Test plan
- SOF, then 5 line_end pulses spaced 800 cycles, each rd_done returned 700 cycles after rd_start, then EOF -> expect:
  - rgb_valid rises after the 3rd line_end;
  - rd_phase values across passes are 3,0,1 without the macro, and 3,0,1,2,3 with it;
  - lines_out is 3 without the macro and 5 with it;
  - afterwards rgb_valid=0 and busy=0.
- SOF, 2 line_end, EOF -> no rd_start; returns to IDLE; lines_in=2.
- Never return rd_done with RD_TIMEOUT=64 -> timeout=1 at cycle 64 after rd_start, then IDLE; err_clr clears it.
- 7 line_end pulses with no rd_done (RD_TIMEOUT large) -> overflow sets on the 5th line_end (lines_in-lines_out=4); wr_line_sel wraps 3->0.
- Mid-frame frame_start after 10 lines -> rgb_valid low one cycle; lines_in=0, rd_phase=3; re-primes after 3 new line_end pulses.
- line_end coincident with rd_done while waiting -> next rd_start within 2 cycles and counts consistent; assert async rst mid-READ -> all outputs at reset values immediately.
